ram_dp_wr_arbiter: RTL and testbench
====================================

# ram_dp_wr_arbiter

Write-side controller for the dual-port RAM, which has a synchronous write port and an asynchronous read port. Two independent requesters share the RAM's single write port through this block. The block clears every RAM location to zero after reset or on command, then grants write requests round-robin through a valid/ready handshake. The RAM read port is outside this block's scope and is wired directly to readers.

## Interface
Parameters:
- WIDTH, 8, data word width; matches the RAM.
- DEPTH, 16, number of RAM words.
- DEPTH_LOG, $clog2(DEPTH), address width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  DEPTH_LOG  requester 0 write address.
- req0_data  input  WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle when asserted together with valid.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0.
- init_start  input  1  single-cycle pulse that requests a full RAM clear.
- busy  output  1  high while a clear is in progress.
- ram_we  output  1  RAM write enable, active-high, registered.
- ram_addr_wr  output  DEPTH_LOG  RAM write address, registered.
- ram_data_wr  output  WIDTH  RAM write data, registered.

## Operation
- The FSM has two states, CLEAR and RUN. Reset forces the CLEAR state, clr_ptr=0 and prio=1, so requester 0 wins the first tie.
- CLEAR, on each edge:
  - register ram_we=1, ram_addr_wr=clr_ptr, ram_data_wr=0;
  - if clr_ptr==DEPTH-1, go to RUN and set clr_ptr=0; otherwise increment clr_ptr.
  - init_start is ignored in this state.
- busy = (state==CLEAR). Both readys are 0 in CLEAR.
- RUN, ready generation (combinational):
  - req0_ready = RUN && !init_start && (!req1_valid || prio==1)
  - req1_ready = RUN && !init_start && (!req0_valid || prio==0)
  - prio holds the index of the last requester served; the other requester wins a tie.
- RUN, accept: at most one write is accepted per cycle, requester i when reqi_valid && reqi_ready. On the edge, register ram_we=1, ram_addr_wr=reqi_addr, ram_data_wr=reqi_data, and set prio=i.
- RUN, no accept: register ram_we=0. ram_addr_wr and ram_data_wr hold their previous values.
- init_start in RUN: on the edge, go to CLEAR with clr_ptr=0. No request is accepted that cycle. prio is unchanged.
- A lone valid requester is granted every cycle, with no bubble.
- Requesters hold valid, addr and data stable until the handshake completes. The block does not check this.
- A reset asserted mid-clear or mid-write aborts immediately: outputs return to reset values and a fresh full clear starts once reset is released.

## Timing
- Reset values: ram_we=0, ram_addr_wr=0, ram_data_wr=0, busy=1, req0_ready=0, req1_ready=0.
- Clear sequence: the first rising edge after reset release produces the address-0 clear write on the outputs.
- busy is high for exactly DEPTH edges after reset release or after the init_start edge. The final clear write (address DEPTH-1) is on the outputs in the same cycle busy first reads 0.
- Write latency is one cycle: a handshake at edge N appears on ram_* during cycle N to N+1, and the RAM captures it at edge N+1.
- Readers see new data on the asynchronous read port from edge N+1 onward.
- Throughput is one write per cycle. With both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- The clear pointer wraps only through the CLEAR-to-RUN transition and never exceeds DEPTH-1. Addresses are not range-checked, since DEPTH_LOG bits always index within DEPTH when DEPTH is a power of 2.

## Test plan
- Reset, then release with no requests: busy=1 for 16 cycles, and ram_we=1 with addresses 0..15 and data 0x00 on consecutive cycles. Afterwards busy=0, ram_we=0, and a read of every address returns 0x00.
- RUN with only req0_valid=1, addr=3, data=0xA5: req0_ready=1 that cycle, and the next cycle shows ram_we=1, addr 3, data 0xA5. Read address 3 returns 0xA5 one edge later.
- RUN with both valid for 4 cycles (req0 data 0x11..0x14, req1 data 0x21..0x24): grant order is req0, req1, req0, req1. The ram_data_wr sequence is 0x11, 0x21, 0x12, 0x22 with ready deasserted on the losing side each cycle.
- In RUN, pulse init_start while req1_valid=1: req1_ready=0 that cycle, busy=1 for the next 16 cycles with both readys 0, after which req1 is accepted.
- Assert rst during clear at clr_ptr=7: ram_we drops to 0 and busy stays 1 immediately. After release, clearing restarts at address 0 and runs all 16 addresses.
- Pulse init_start while busy=1: no effect, and the clear ends on schedule after 16 total cycles.

Source files
------------

// File: rtl/ram_dp_wr_arbiter.sv
// ram_dp_wr_arbiter
//   Write-side controller for a dual-port RAM with a synchronous write port.
//   After reset, or on an init_start pulse, it writes zero to every RAM word.
//   It then shares the single write port between two requesters using a
//   round-robin valid/ready handshake.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   reqN_valid/addr/data    : write request from requester N (N = 0, 1)
//   reqN_ready              : request N is accepted when valid && ready
//   init_start              : one-cycle pulse that starts a full RAM clear (RUN only)
//   busy                    : high while a clear is in progress
//   ram_we/addr_wr/data_wr  : registered write port toward the RAM
module ram_dp_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [DEPTH_LOG-1:0] req0_addr,
    input  logic [WIDTH-1:0]     req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DEPTH_LOG-1:0] req1_addr,
    input  logic [WIDTH-1:0]     req1_data,
    output logic                 req1_ready,
    input  logic                 init_start,
    output logic                 busy,
    output logic                 ram_we,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [WIDTH-1:0]     ram_data_wr
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] clr_ptr_q, clr_ptr_d;
    logic                 prio_q, prio_d;     // index of the last requester served
    logic                 ram_we_q, ram_we_d;
    logic [DEPTH_LOG-1:0] ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0]     ram_data_q, ram_data_d;

    logic run;
    logic accept0;
    logic accept1;

    // A pending init_start blocks both grants so the clear never races a write.
    // The tie goes to the requester that was not served last.
    assign run        = (state_q == RUN);
    assign req0_ready = run && !init_start && (!req1_valid || prio_q == 1'b1);
    assign req1_ready = run && !init_start && (!req0_valid || prio_q == 1'b0);
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    assign busy        = (state_q == CLEAR);
    assign ram_we      = ram_we_q;
    assign ram_addr_wr = ram_addr_q;
    assign ram_data_wr = ram_data_q;

    // NOTE: every signal written here gets a default first so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        prio_d     = prio_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        case (state_q)
            CLEAR: begin
                ram_we_d   = 1'b1;
                ram_addr_d = clr_ptr_q;
                ram_data_d = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + DEPTH_LOG'(1);
                end
            end
            RUN: begin
                if (init_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else if (accept0) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = req0_addr;
                    ram_data_d = req0_data;
                    prio_d     = 1'b0;
                end else if (accept1) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = req1_addr;
                    ram_data_d = req1_data;
                    prio_d     = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            prio_q     <= 1'b1;   // requester 0 wins the first tie
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            prio_q     <= prio_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

endmodule

// File: tb/tb_ram_dp_wr_arbiter.sv
// Testbench for ram_dp_wr_arbiter: directed vectors plus multi-cycle
// sequences for clear, init_start and reset-during-clear. A behavioural RAM
// stands in for the real RAM so the asynchronous read side can be checked.
module tb_ram_dp_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       init_start;
    logic       busy;
    logic       ram_we;
    logic [3:0] ram_addr_wr;
    logic [7:0] ram_data_wr;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];

    ram_dp_wr_arbiter #(.WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_start (init_start),
        .busy       (busy),
        .ram_we     (ram_we),
        .ram_addr_wr(ram_addr_wr),
        .ram_data_wr(ram_data_wr)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_wr] <= ram_data_wr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Follows a full clear: one write of zero per edge to addresses 0..15.
    // Optionally pulses init_start at step pulse_at to show it is ignored.
    task automatic clear_run(input string tag, input int pulse_at);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            init_start = 1'b0;
            check({tag, " we"},   ram_we, 1);
            check({tag, " addr"}, ram_addr_wr, k);
            check({tag, " data"}, ram_data_wr, 0);
            check({tag, " busy"}, busy, (k < 15) ? 1 : 0);
            if (k < 15) begin
                check({tag, " r0_ready"}, req0_ready, 0);
                check({tag, " r1_ready"}, req1_ready, 0);
            end
            if (k == pulse_at) init_start = 1'b1;
        end
    endtask

    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic       e_r0;
        logic       e_r1;
        logic       e_we;
        logic [3:0] e_a;
        logic [7:0] e_d;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Priority starts at 1 (req0 wins ties); each grant moves it to the winner.
        vecs[0] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1, 1'b0, 4'd15, 8'h00};
        vecs[1] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b1, 4'd3,  8'hA5};
        vecs[2] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1, 1'b0, 4'd3,  8'hA5};
        vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h5A, 1'b0, 1'b1, 1'b1, 4'd5,  8'h5A};
        vecs[4] = '{1'b1, 4'd8,  8'h11, 1'b1, 4'd12, 8'h21, 1'b1, 1'b0, 1'b1, 4'd8,  8'h11};
        vecs[5] = '{1'b1, 4'd9,  8'h12, 1'b1, 4'd12, 8'h21, 1'b0, 1'b1, 1'b1, 4'd12, 8'h21};
        vecs[6] = '{1'b1, 4'd9,  8'h12, 1'b1, 4'd13, 8'h22, 1'b1, 1'b0, 1'b1, 4'd9,  8'h12};
        vecs[7] = '{1'b1, 4'd10, 8'h13, 1'b1, 4'd13, 8'h22, 1'b0, 1'b1, 1'b1, 4'd13, 8'h22};

        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        init_start = 1'b0;

        // Reset values
        #12;
        check("rst we",       ram_we, 0);
        check("rst addr",     ram_addr_wr, 0);
        check("rst data",     ram_data_wr, 0);
        check("rst busy",     busy, 1);
        check("rst r0_ready", req0_ready, 0);
        check("rst r1_ready", req1_ready, 0);

        // Initial clear, with an init_start pulse mid-clear that must be ignored
        @(negedge clk);
        rst = 1'b0;
        clear_run("clr0", 5);
        @(posedge clk);
        #1;
        check("post-clear we", ram_we, 0);
        for (int a = 0; a < 16; a++) check($sformatf("clr0 mem[%0d]", a), mem[a], 0);

        // Directed vectors in RUN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
            #1;
            check($sformatf("v%0d r0_ready", i), req0_ready, vecs[i].e_r0);
            check($sformatf("v%0d r1_ready", i), req1_ready, vecs[i].e_r1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d we", i),   ram_we, vecs[i].e_we);
            check($sformatf("v%0d addr", i), ram_addr_wr, vecs[i].e_a);
            check($sformatf("v%0d data", i), ram_data_wr, vecs[i].e_d);
            check($sformatf("v%0d busy", i), busy, 0);
        end

        // Idle edge lets the last write land, then read back through the RAM
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle we",  ram_we, 0);
        check("mem[3]",   mem[3], 8'hA5);
        check("mem[5]",   mem[5], 8'h5A);
        check("mem[8]",   mem[8], 8'h11);
        check("mem[12]",  mem[12], 8'h21);
        check("mem[9]",   mem[9], 8'h12);
        check("mem[13]",  mem[13], 8'h22);
        check("mem[10]",  mem[10], 8'h00);

        // init_start in RUN while req1 is waiting
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = 4'd14; req1_data = 8'h33;
        init_start = 1'b1;
        #1;
        check("init r1_ready", req1_ready, 0);
        check("init r0_ready", req0_ready, 0);
        @(posedge clk);
        #1;
        check("init busy", busy, 1);
        check("init we",   ram_we, 0);
        init_start = 1'b0;
        clear_run("clr1", -1);
        check("clr1 end r1_ready", req1_ready, 1);
        @(posedge clk);
        #1;
        check("clr1 req1 we",   ram_we, 1);
        check("clr1 req1 addr", ram_addr_wr, 14);
        check("clr1 req1 data", ram_data_wr, 8'h33);
        check("clr1 mem[3]",    mem[3], 8'h00);
        req1_valid = 1'b0;

        // Reset in the middle of a clear, at clr_ptr = 7
        @(negedge clk);
        init_start = 1'b1;
        @(posedge clk);
        #1;
        init_start = 1'b0;
        for (int k = 0; k < 7; k++) @(posedge clk);
        #1;
        check("pre-rst addr", ram_addr_wr, 6);
        #2;
        rst = 1'b1;
        #1;
        check("mid-rst we",   ram_we, 0);
        check("mid-rst busy", busy, 1);
        check("mid-rst addr", ram_addr_wr, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_run("clr2", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
